// File: rtl/alu_issue_if.sv
// alu_issue_if: issue-stage bundle (instruction handshake, ALU drive/return, retire status, debug read)
//   master: instruction producer / ALU / debug host side
//   slave : alu_issue_ctrl side
//   Optional zflag signal present when ALU_ZERO_FLAG_EN is defined.
interface alu_issue_if #(
   parameter int DATA_W = 4,
   parameter int RA_W   = 2
);
   logic              in_valid;
   logic              in_ready;
   logic [12:0]       instr;
   logic              alu_en;
   logic              alu_cin;
   logic [3:0]        alu_op;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_y;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] result;
   logic [RA_W-1:0]   dbg_addr;
   logic [DATA_W-1:0] dbg_data;
`ifdef ALU_ZERO_FLAG_EN
   logic              zflag;
`endif
   modport slave (
      input  in_valid, instr, alu_y, dbg_addr,
      output in_ready, alu_en, alu_cin, alu_op, alu_a, alu_b, done, err, result, dbg_data
`ifdef ALU_ZERO_FLAG_EN
      , output zflag
`endif
   );
   modport master (
      output in_valid, instr, alu_y, dbg_addr,
      input  in_ready, alu_en, alu_cin, alu_op, alu_a, alu_b, done, err, result, dbg_data
`ifdef ALU_ZERO_FLAG_EN
      , input zflag
`endif
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/control stage driving a 4-bit registered ALU with a 4x4 register file
//   clk, rst_n (async active-low)
//   bus.slave: in_valid/in_ready/instr handshake; alu_en/cin/op/a/b to ALU, alu_y back;
//              done/err/result retire pulse; dbg_addr/dbg_data combinational regfile read;
//              zflag (result==0 of last non-error writeback) when ALU_ZERO_FLAG_EN is defined.
module alu_issue_ctrl #(
   parameter int DATA_W = 4,
   parameter int NREG   = 4,
   parameter int RA_W   = 2
) (
   input logic        clk,
   input logic        rst_n,
   alu_issue_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;
   state_t            state, state_nx;
   logic [12:0]       ir;
   logic [DATA_W-1:0] rf [NREG];
   logic [DATA_W-1:0] wval;
   logic              accept, in_alu, ir_ill;
   // Only combinations with a fully defined ALU result are legal.
   function automatic logic legal(input logic [3:0] op, input logic cin);
      return op < 4'd4 || (!cin && op <= 4'd8);
   endfunction
   assign accept = state == IDLE && bus.in_valid;
   assign in_alu = !bus.instr[12] && legal(bus.instr[11:8], bus.instr[7]);
   assign ir_ill = !ir[12] && !legal(ir[11:8], ir[7]);
   assign wval   = ir[12] ? DATA_W'(ir[3:0]) : ir_ill ? '0 : bus.alu_y;
   assign bus.dbg_data = rf[bus.dbg_addr];
   always_comb begin
      state_nx     = IDLE;
      bus.in_ready = state == IDLE;
      bus.alu_en   = state == ISSUE;
      bus.done     = state == WB;
      bus.err      = state == WB && ir_ill;
      bus.result   = state == WB ? wval : '0;
      if (state == IDLE) state_nx = !bus.in_valid ? IDLE : in_alu ? ISSUE : WB;
      else if (state == ISSUE) state_nx = WB;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ir          <= '0;
         bus.alu_a   <= '0;
         bus.alu_b   <= '0;
         bus.alu_op  <= '0;
         bus.alu_cin <= 1'b0;
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
`ifdef ALU_ZERO_FLAG_EN
         bus.zflag   <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         if (accept) ir <= bus.instr;
         // Operands are sampled on the accept edge so they are stable throughout ISSUE.
         if (accept && in_alu) begin
            bus.alu_a   <= rf[bus.instr[4:3]];
            bus.alu_b   <= rf[bus.instr[2:1]];
            bus.alu_op  <= bus.instr[11:8];
            bus.alu_cin <= bus.instr[7];
         end
         if (state == WB && !ir_ill) begin
            rf[ir[6:5]] <= wval;
`ifdef ALU_ZERO_FLAG_EN
            bus.zflag   <= wval == '0;
`endif
         end
      end
   end
endmodule
